// File: rtl/axis_route_ctrl_pkg.sv
// axis_route_ctrl_pkg: shared types and helpers for the route controller.
//   route_t      - 8-bit route vector {rsvd, dtu_dest, host_dest}
//   slot_state_e - per-region update state (idle / pending)
//   popcount8    - number of set bits in an 8-bit vector
package axis_route_ctrl_pkg;

  localparam int ROUTE_BITS = 8;
  localparam int N_REGIONS  = 4;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [1:0] dtu_dest;
    logic [1:0] host_dest;
  } route_t;

  typedef enum logic [0:0] {
    SLOT_IDLE = 1'b0,
    SLOT_PEND = 1'b1
  } slot_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] vec);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, vec[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/axis_route_ctrl_if.sv
// axis_route_ctrl_if: control-path route update channel plus the snooped
// per-region host/dtu stream handshakes.
//   cfg_valid/cfg_ready/cfg_region/cfg_route - update request handshake
//   host_t*/dtu_t*                           - per-region sink handshakes
// modport master: control path and stream environment
// modport slave : the route controller
interface axis_route_ctrl_if
  import axis_route_ctrl_pkg::*;
#(
  parameter int N_ID = N_REGIONS
) ();

  localparam int RB = (N_ID > 1) ? $clog2(N_ID) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [RB-1:0]   cfg_region;
  route_t          cfg_route;
  logic [N_ID-1:0] host_tvalid;
  logic [N_ID-1:0] host_tready;
  logic [N_ID-1:0] host_tlast;
  logic [N_ID-1:0] dtu_tvalid;
  logic [N_ID-1:0] dtu_tready;
  logic [N_ID-1:0] dtu_tlast;

  modport master (
    output cfg_valid, cfg_region, cfg_route,
    output host_tvalid, host_tready, host_tlast,
    output dtu_tvalid, dtu_tready, dtu_tlast,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_region, cfg_route,
    input  host_tvalid, host_tready, host_tlast,
    input  dtu_tvalid, dtu_tready, dtu_tlast,
    output cfg_ready
  );

endinterface

// File: rtl/axis_route_ctrl_route_slot.sv
// axis_route_ctrl_route_slot: one region's route holder. Latches an update,
// waits until both streams are between packets, then commits it.
//   aclk, areset          - clock, async active-high reset
//   cfg_we, cfg_route     - accepted update for this region
//   host_t*, dtu_t*       - snooped sink handshakes of this region
//   tmo_clr               - clears the sticky timeout flag
//   route                 - committed route (registered)
//   pending, tmo_err      - update waiting / update stuck too long
//   commit                - single-cycle strobe in the commit cycle
module axis_route_ctrl_route_slot
  import axis_route_ctrl_pkg::*;
#(
  parameter logic [ROUTE_BITS-1:0] ROUTE_RST  = 8'h00,
  parameter int                    TMO_CYCLES = 4096,
  parameter int                    TMO_BITS   = 16
) (
  input  logic   aclk,
  input  logic   areset,
  input  logic   cfg_we,
  input  route_t cfg_route,
  input  logic   host_tvalid,
  input  logic   host_tready,
  input  logic   host_tlast,
  input  logic   dtu_tvalid,
  input  logic   dtu_tready,
  input  logic   dtu_tlast,
  input  logic   tmo_clr,
  output route_t route,
  output logic   pending,
  output logic   tmo_err,
  output logic   commit
);

  localparam logic [TMO_BITS-1:0] TMO_MAX = TMO_BITS'(TMO_CYCLES);

  slot_state_e         state_r;
  slot_state_e         state_nxt_s;
  route_t              pend_route_r;
  route_t              route_r;
  logic                in_pkt_host_r;
  logic                in_pkt_dtu_r;
  logic                tmo_err_r;
  logic [TMO_BITS-1:0] tmo_cnt_r;
  logic [TMO_BITS-1:0] tmo_cnt_nxt_s;
  logic                host_hs_s;
  logic                dtu_hs_s;
  logic                boundary_s;
  logic                commit_s;
  logic                tmo_set_s;

  assign host_hs_s = host_tvalid & host_tready;
  assign dtu_hs_s  = dtu_tvalid & dtu_tready;

  // A first/middle beat handshaking this cycle also blocks: that packet must
  // go out entirely with the old route. A closing beat does not block.
  assign boundary_s = !in_pkt_host_r && !in_pkt_dtu_r &&
                      !(host_hs_s && !host_tlast) &&
                      !(dtu_hs_s && !dtu_tlast);

  // Next state, commit strobe and timeout counter update
  always_comb begin
    state_nxt_s   = state_r;
    commit_s      = 1'b0;
    tmo_cnt_nxt_s = {TMO_BITS{1'b0}};
    tmo_set_s     = 1'b0;
    case (state_r)
      SLOT_IDLE: begin
        if (cfg_we) begin
          state_nxt_s = SLOT_PEND;
        end else begin
          state_nxt_s = SLOT_IDLE;
        end
      end
      SLOT_PEND: begin
        if (boundary_s) begin
          state_nxt_s = SLOT_IDLE;
          commit_s    = 1'b1;
        end else begin
          state_nxt_s = SLOT_PEND;
          if (tmo_cnt_r >= TMO_MAX) begin
            tmo_cnt_nxt_s = TMO_MAX;
          end else begin
            tmo_cnt_nxt_s = tmo_cnt_r + TMO_BITS'(1);
          end
          // Re-asserted every cycle while saturated, so a clear cannot
          // drop the flag while the update is still stuck.
          tmo_set_s = (tmo_cnt_nxt_s == TMO_MAX);
        end
      end
      default: begin
        state_nxt_s = SLOT_IDLE;
      end
    endcase
  end

  // State register and timeout counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r   <= SLOT_IDLE;
      tmo_cnt_r <= {TMO_BITS{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end

  // Pending and committed route registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pend_route_r <= route_t'(8'h00);
      route_r      <= route_t'(ROUTE_RST);
    end else begin
      if (cfg_we && (state_r == SLOT_IDLE)) begin
        pend_route_r <= cfg_route;
      end
      if (commit_s) begin
        route_r <= pend_route_r;
      end
    end
  end

  // In-packet tracking; a single-beat packet leaves the flag clear
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      in_pkt_host_r <= 1'b0;
      in_pkt_dtu_r  <= 1'b0;
    end else begin
      if (host_hs_s) begin
        in_pkt_host_r <= !host_tlast;
      end
      if (dtu_hs_s) begin
        in_pkt_dtu_r <= !dtu_tlast;
      end
    end
  end

  // Sticky timeout flag; set has priority over clear
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmo_err_r <= 1'b0;
    end else if (tmo_set_s) begin
      tmo_err_r <= 1'b1;
    end else if (tmo_clr) begin
      tmo_err_r <= 1'b0;
    end
  end

  assign route   = route_r;
  assign pending = (state_r == SLOT_PEND);
  assign tmo_err = tmo_err_r;
  assign commit  = commit_s;

endmodule

// File: rtl/axis_route_ctrl.sv
// axis_route_ctrl: produces the per-region route vectors for the vFPGA data
// switch, applying control-path updates only at packet boundaries.
//   aclk, areset - clock, async active-high reset
//   bus          - cfg request channel and snooped stream handshakes
//   route_out    - committed route per region (registered)
//   pending      - per-region update waiting for a boundary
//   tmo_err      - per-region sticky timeout flag, tmo_clr clears it
//   commit_cnt   - total committed updates, wrapping
module axis_route_ctrl
  import axis_route_ctrl_pkg::*;
#(
  parameter int                    N_ID       = N_REGIONS,
  parameter logic [ROUTE_BITS-1:0] ROUTE_RST  = 8'h00,
  parameter int                    TMO_CYCLES = 4096,
  parameter int                    TMO_BITS   = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  axis_route_ctrl_if.slave     bus,
  output route_t [N_ID-1:0]    route_out,
  output logic   [N_ID-1:0]    pending,
  output logic   [N_ID-1:0]    tmo_err,
  input  logic   [N_ID-1:0]    tmo_clr,
  output logic   [31:0]        commit_cnt
);

  localparam int RB = (N_ID > 1) ? $clog2(N_ID) : 1;

  logic [N_ID-1:0] pending_s;
  logic [N_ID-1:0] commit_s;
  logic [N_ID-1:0] cfg_we_s;
  logic            sel_pend_s;
  logic            cfg_fire_s;
  logic [31:0]     commit_cnt_r;

  // Pending flag of the addressed region; an unpopulated region reads idle
  // so a request to it is accepted and dropped rather than stalling.
  always_comb begin
    sel_pend_s = 1'b0;
    for (int i = 0; i < N_ID; i++) begin
      sel_pend_s = sel_pend_s | (pending_s[i] & (bus.cfg_region == RB'(i)));
    end
  end

  assign bus.cfg_ready = !areset && !sel_pend_s;
  assign cfg_fire_s    = bus.cfg_valid && bus.cfg_ready;

  // Decode the accepted request into a per-region write strobe
  always_comb begin
    cfg_we_s = {N_ID{1'b0}};
    for (int i = 0; i < N_ID; i++) begin
      cfg_we_s[i] = cfg_fire_s & (bus.cfg_region == RB'(i));
    end
  end

  for (genvar g = 0; g < N_ID; g++) begin : g_slot
    axis_route_ctrl_route_slot #(
      .ROUTE_RST  (ROUTE_RST),
      .TMO_CYCLES (TMO_CYCLES),
      .TMO_BITS   (TMO_BITS)
    ) u_slot (
      .aclk        (aclk),
      .areset      (areset),
      .cfg_we      (cfg_we_s[g]),
      .cfg_route   (bus.cfg_route),
      .host_tvalid (bus.host_tvalid[g]),
      .host_tready (bus.host_tready[g]),
      .host_tlast  (bus.host_tlast[g]),
      .dtu_tvalid  (bus.dtu_tvalid[g]),
      .dtu_tready  (bus.dtu_tready[g]),
      .dtu_tlast   (bus.dtu_tlast[g]),
      .tmo_clr     (tmo_clr[g]),
      .route       (route_out[g]),
      .pending     (pending_s[g]),
      .tmo_err     (tmo_err[g]),
      .commit      (commit_s[g])
    );
  end

  // Commit counter; several regions may commit in one cycle (N_ID <= 8)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      commit_cnt_r <= 32'd0;
    end else begin
      commit_cnt_r <= commit_cnt_r + {28'd0, popcount8(8'(commit_s))};
    end
  end

  assign pending    = pending_s;
  assign commit_cnt = commit_cnt_r;

endmodule

// File: tb/tb_axis_route_ctrl.sv
// tb_axis_route_ctrl: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the route controller.
module tb_axis_route_ctrl;
  import axis_route_ctrl_pkg::*;

  localparam int          N         = 4;
  localparam int          TMO       = 20;
  localparam int          TBITS     = 8;
  localparam logic [7:0]  RST_ROUTE = 8'h31;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axis_route_ctrl_if #(.N_ID(N)) ifc ();
  route_t [N-1:0] route_out;
  logic   [N-1:0] pending;
  logic   [N-1:0] tmo_err;
  logic   [N-1:0] tmo_clr;
  logic   [31:0]  commit_cnt;

  axis_route_ctrl #(
    .N_ID       (N),
    .ROUTE_RST  (RST_ROUTE),
    .TMO_CYCLES (TMO),
    .TMO_BITS   (TBITS)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .bus        (ifc),
    .route_out  (route_out),
    .pending    (pending),
    .tmo_err    (tmo_err),
    .tmo_clr    (tmo_clr),
    .commit_cnt (commit_cnt)
  );

  // Reference model: committed routes, waiting updates with their acceptance
  // cycle, open packets per stream, sticky flags and the commit total.
  logic [7:0]  m_route [N];
  logic [7:0]  m_want  [N];
  bit          m_wait  [N];
  int          m_since [N];
  bit          m_open_h[N];
  bit          m_open_d[N];
  bit          m_tmo   [N];
  logic [31:0] m_total;
  int          cyc;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_route[i]  = RST_ROUTE;
      m_want[i]   = 8'h00;
      m_wait[i]   = 1'b0;
      m_since[i]  = 0;
      m_open_h[i] = 1'b0;
      m_open_d[i] = 1'b0;
      m_tmo[i]    = 1'b0;
    end
    m_total = 32'd0;
  endtask

  function automatic bit exp_ready();
    return (areset === 1'b0) && !m_wait[ifc.cfg_region];
  endfunction

  task automatic idle_inputs();
    ifc.cfg_valid   = 1'b0;
    ifc.cfg_region  = 2'd0;
    ifc.cfg_route   = route_t'(8'h00);
    ifc.host_tvalid = 4'd0;
    ifc.host_tready = 4'd0;
    ifc.host_tlast  = 4'd0;
    ifc.dtu_tvalid  = 4'd0;
    ifc.dtu_tready  = 4'd0;
    ifc.dtu_tlast   = 4'd0;
    tmo_clr         = 4'd0;
  endtask

  // One clock: check cfg_ready, advance the model, then compare all outputs.
  task automatic tick();
    bit acc;
    bit busy;
    bit set;
    logic [N-1:0] ep;
    logic [N-1:0] et;
    @(negedge aclk);
    check("cfg_ready", {63'd0, ifc.cfg_ready}, {63'd0, exp_ready()});
    acc = ifc.cfg_valid && exp_ready();
    for (int i = 0; i < N; i++) begin
      // a beat that opens or continues a packet makes this cycle unsafe
      busy = m_open_h[i] || m_open_d[i] ||
             (ifc.host_tvalid[i] && ifc.host_tready[i] && !ifc.host_tlast[i]) ||
             (ifc.dtu_tvalid[i] && ifc.dtu_tready[i] && !ifc.dtu_tlast[i]);
      set = 1'b0;
      if (m_wait[i]) begin
        if (!busy) begin
          m_route[i] = m_want[i];
          m_wait[i]  = 1'b0;
          m_total    = m_total + 32'd1;
        end else if (cyc - m_since[i] >= TMO) begin
          set = 1'b1;
        end
      end else if (acc && (int'(ifc.cfg_region) == i)) begin
        m_wait[i]  = 1'b1;
        m_want[i]  = ifc.cfg_route;
        m_since[i] = cyc;
      end
      m_tmo[i] = set || (m_tmo[i] && !tmo_clr[i]);
      if (ifc.host_tvalid[i] && ifc.host_tready[i]) m_open_h[i] = !ifc.host_tlast[i];
      if (ifc.dtu_tvalid[i] && ifc.dtu_tready[i])   m_open_d[i] = !ifc.dtu_tlast[i];
    end
    cyc++;
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      check("route_out", {56'd0, route_out[i]}, {56'd0, m_route[i]});
      ep[i] = m_wait[i];
      et[i] = m_tmo[i];
    end
    check("pending", {60'd0, pending}, {60'd0, ep});
    check("tmo_err", {60'd0, tmo_err}, {60'd0, et});
    check("commit_cnt", {32'd0, commit_cnt}, {32'd0, m_total});
  endtask

  initial begin
    cyc = 0;
    areset = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check("rst_ready", {63'd0, ifc.cfg_ready}, 64'd0);
    check("rst_route", {56'd0, route_out[3]}, {56'd0, RST_ROUTE});
    check("rst_cnt", {32'd0, commit_cnt}, 64'd0);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Idle update: region 1 <- 06, no traffic
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd1; ifc.cfg_route = route_t'(8'h06);
    tick();
    idle_inputs();
    check("idle_pend", {63'd0, pending[1]}, 64'd1);
    check("idle_old", {56'd0, route_out[1]}, {56'd0, RST_ROUTE});
    tick();
    check("idle_new", {56'd0, route_out[1]}, 64'h06);
    check("idle_cnt", {32'd0, commit_cnt}, 64'd1);

    // Mid-packet defer: 4-beat host packet on region 0
    ifc.host_tvalid = 4'b0001; ifc.host_tready = 4'b0001;
    tick();
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd0; ifc.cfg_route = route_t'(8'h0A);
    tick();
    ifc.cfg_valid = 1'b0;
    tick();
    ifc.host_tlast = 4'b0001;
    tick();
    check("defer_hold", {56'd0, route_out[0]}, {56'd0, RST_ROUTE});
    idle_inputs();
    tick();
    check("defer_new", {56'd0, route_out[0]}, 64'h0A);

    // Same-cycle first beat on dtu stream of region 2
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd2; ifc.cfg_route = route_t'(8'h0C);
    tick();
    idle_inputs();
    ifc.dtu_tvalid = 4'b0100; ifc.dtu_tready = 4'b0100;
    tick();
    check("first_beat_pend", {63'd0, pending[2]}, 64'd1);
    ifc.dtu_tlast = 4'b0100;
    tick();
    check("first_beat_old", {56'd0, route_out[2]}, {56'd0, RST_ROUTE});
    idle_inputs();
    tick();
    check("first_beat_new", {56'd0, route_out[2]}, 64'h0C);

    // Back-pressure on pending region 2, region 0 still accepted
    ifc.dtu_tvalid = 4'b0100; ifc.dtu_tready = 4'b0100;
    tick();
    ifc.dtu_tvalid = 4'd0; ifc.dtu_tready = 4'd0;
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd2; ifc.cfg_route = route_t'(8'h03);
    tick();
    ifc.cfg_route = route_t'(8'h0F);
    #1;
    check("bp_ready_lo", {63'd0, ifc.cfg_ready}, 64'd0);
    tick();
    ifc.cfg_region = 2'd0; ifc.cfg_route = route_t'(8'h05);
    #1;
    check("bp_ready_hi", {63'd0, ifc.cfg_ready}, 64'd1);
    tick();
    ifc.cfg_region = 2'd2; ifc.cfg_route = route_t'(8'h0F);
    ifc.dtu_tvalid = 4'b0100; ifc.dtu_tready = 4'b0100; ifc.dtu_tlast = 4'b0100;
    tick();
    ifc.dtu_tvalid = 4'd0; ifc.dtu_tready = 4'd0; ifc.dtu_tlast = 4'd0;
    tick();
    tick();
    tick();
    ifc.cfg_valid = 1'b0;
    tick();
    check("bp_r2", {56'd0, route_out[2]}, 64'h0F);
    check("bp_r0", {56'd0, route_out[0]}, 64'h05);

    // Timeout: region 0 host packet held open with an update pending
    idle_inputs();
    ifc.host_tvalid = 4'b0001; ifc.host_tready = 4'b0001;
    tick();
    idle_inputs();
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd0; ifc.cfg_route = route_t'(8'h09);
    tick();
    idle_inputs();
    for (int k = 0; k < TMO + 5; k++) tick();
    check("tmo_set", {63'd0, tmo_err[0]}, 64'd1);
    tmo_clr = 4'b0001;
    tick();
    tmo_clr = 4'd0;
    check("tmo_clr_blocked", {63'd0, tmo_err[0]}, 64'd1);
    ifc.host_tvalid = 4'b0001; ifc.host_tready = 4'b0001; ifc.host_tlast = 4'b0001;
    tick();
    idle_inputs();
    tick();
    check("tmo_commit", {56'd0, route_out[0]}, 64'h09);
    tmo_clr = 4'b0001;
    tick();
    tmo_clr = 4'd0;
    check("tmo_cleared", {63'd0, tmo_err[0]}, 64'd0);

    // Reset while region 1 is pending
    ifc.host_tvalid = 4'b0010; ifc.host_tready = 4'b0010;
    tick();
    idle_inputs();
    ifc.cfg_valid = 1'b1; ifc.cfg_region = 2'd1; ifc.cfg_route = route_t'(8'h0E);
    tick();
    idle_inputs();
    check("rst_pend_before", {63'd0, pending[1]}, 64'd1);
    areset = 1'b1;
    #2;
    model_reset();
    check("rst_mid_route", {56'd0, route_out[1]}, {56'd0, RST_ROUTE});
    check("rst_mid_pend", {60'd0, pending}, 64'd0);
    check("rst_mid_ready", {63'd0, ifc.cfg_ready}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("rst_lost", {56'd0, route_out[1]}, {56'd0, RST_ROUTE});

    // Random traffic and updates
    for (int k = 0; k < 1500; k++) begin
      ifc.cfg_valid   = ($urandom_range(0, 2) == 0);
      ifc.cfg_region  = 2'($urandom_range(0, N - 1));
      ifc.cfg_route   = route_t'(8'($urandom));
      ifc.host_tvalid = 4'($urandom);
      ifc.host_tready = 4'($urandom) | 4'($urandom);
      ifc.host_tlast  = 4'($urandom) & 4'($urandom);
      ifc.dtu_tvalid  = 4'($urandom);
      ifc.dtu_tready  = 4'($urandom) | 4'($urandom);
      ifc.dtu_tlast   = 4'($urandom) & 4'($urandom);
      tmo_clr         = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
